// File: rtl/pipe_ctrl_n.sv
// pipe_ctrl_n -- pipeline hazard / exception controller
//
// Purpose:
//   Produces per-stage hold signals from per-stage stall requests and from
//   load-use bubbles. It sequences exception redirects: an exception either
//   flushes at once or waits until younger stages stop stalling. A watchdog
//   flags pipelines that stay stalled for too long.
//
// Parameters:
//   STAGES      number of controlled stages (0 = PC/IF, STAGES-1 = WB)
//   ID_IDX      decode stage index (load-use bubble source)
//   EXCP_IDX    stage index where exceptions are detected
//   LOAD_BUBBLE stall cycles per load-use hazard (1..15)
//   TMO_W       width of the stall watchdog counter
//
// Ports:
//   clk        in   clock, rising edge
//   resetn     in   asynchronous active-low reset
//   stallreq   in   [STAGES] per-stage stall request
//   load_use   in   decode load-use hazard
//   excp_req   in   exception pulse from stage EXCP_IDX
//   excp_pc    in   [32] handler PC for excp_req
//   stall      out  [STAGES] per-stage hold (combinational)
//   flush      out  registered one-cycle flush pulse
//   new_pc     out  [32] redirect PC, valid while flush=1
//   stall_tmo  out  sticky watchdog flag
module pipe_ctrl_n #(
  parameter int STAGES      = 6,
  parameter int ID_IDX      = 2,
  parameter int EXCP_IDX    = 4,
  parameter int LOAD_BUBBLE = 1,
  parameter int TMO_W       = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [STAGES-1:0] stallreq,
  input  logic              load_use,
  input  logic              excp_req,
  input  logic [31:0]       excp_pc,
  output logic [STAGES-1:0] stall,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic              stall_tmo
);

  typedef enum logic [1:0] {IDLE, LOAD, PEND, FLUSH} state_t;

  localparam logic [STAGES-1:0] ONES       = {STAGES{1'b1}};
  localparam logic [STAGES-1:0] ABOVE_ID   = ONES << (ID_IDX + 1);
  localparam logic [STAGES-1:0] ABOVE_EXCP = ONES << (EXCP_IDX + 1);
  localparam logic [STAGES-1:0] ID_BIT     = {{(STAGES-1){1'b0}}, 1'b1} << ID_IDX;

  // Counter value on entering LOAD. When the hazard cycle itself was not
  // blocked by a younger stall it already served as the first bubble.
  localparam logic [3:0] CNT_BLOCKED = 4'(LOAD_BUBBLE - 1);
  localparam logic [3:0] CNT_FREE    = 4'(LOAD_BUBBLE - 2);

  state_t             r_state;
  logic [3:0]         r_cnt;
  logic               r_flush;
  logic [31:0]        r_newPc;
  logic [TMO_W-1:0]   r_wd;
  logic               r_tmo;

  logic               w_blockId;
  logic               w_blockEx;
  logic               w_loadStart;
  logic               w_idSrc;
  logic [STAGES-1:0]  w_src;
  logic [STAGES-1:0]  w_stall;
  logic [TMO_W-1:0]   w_wdNext;

  // A younger stage stalling means the bubble (or the flush) cannot
  // advance, so the bubble is not consumed / the exception must wait.
  assign w_blockId   = |(stallreq & ABOVE_ID);
  assign w_blockEx   = |(stallreq & ABOVE_EXCP);
  // Load-use stalls decode in the hazard cycle itself; an exception wins.
  // Reset masks it so only stallreq drives stall during reset.
  assign w_loadStart = resetn && (r_state == IDLE) && load_use && !excp_req;
  assign w_idSrc     = (r_state == LOAD) || w_loadStart;
  assign w_src       = stallreq | (w_idSrc ? ID_BIT : '0);

  // Highest active source k freezes stages 0..k: prefix-OR from the top.
  always_comb begin : stallGen
    logic acc;
    acc     = 1'b0;
    w_stall = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc        = acc | w_src[i];
      w_stall[i] = acc;
    end
    if (r_state == FLUSH) begin
      w_stall = '0;
    end
  end

  // Control FSM with registered flush and captured redirect PC.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_flush <= 1'b0;
      r_newPc <= 32'd0;
    end else begin
      r_flush <= 1'b0;
      case (r_state)
        IDLE, LOAD: begin
          if (excp_req) begin
            r_newPc <= excp_pc;
            r_cnt   <= 4'd0;
            if (w_blockEx) begin
              r_state <= PEND;
            end else begin
              r_state <= FLUSH;
              r_flush <= 1'b1;
            end
          end else if (r_state == LOAD) begin
            if (!w_blockId) begin
              if (r_cnt == 4'd0) begin
                r_state <= IDLE;
              end else begin
                r_cnt <= r_cnt - 4'd1;
              end
            end
          end else if (load_use) begin
            if (w_blockId) begin
              r_state <= LOAD;
              r_cnt   <= CNT_BLOCKED;
            end else if (LOAD_BUBBLE > 1) begin
              r_state <= LOAD;
              r_cnt   <= CNT_FREE;
            end
          end
        end
        PEND: begin
          if (!w_blockEx) begin
            r_state <= FLUSH;
            r_flush <= 1'b1;
          end
        end
        FLUSH: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Watchdog counts consecutive stalled cycles and saturates; the flag is
  // raised on the same edge the counter reaches all ones.
  always_comb begin
    w_wdNext = '0;
    if (|w_stall) begin
      w_wdNext = (&r_wd) ? r_wd : r_wd + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wd  <= '0;
      r_tmo <= 1'b0;
    end else begin
      r_wd <= w_wdNext;
      if (&w_wdNext) begin
        r_tmo <= 1'b1;
      end
    end
  end

  assign stall     = w_stall;
  assign flush     = r_flush;
  assign new_pc    = r_newPc;
  assign stall_tmo = r_tmo;

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Bench for pipe_ctrl_n: two instances (defaults, and LOAD_BUBBLE=3/TMO_W=4)
// share stimulus; a behavioural model per instance is compared every cycle,
// and directed sequences pin literal expectations.
module tb_pipe_ctrl_n;

  logic        clk;
  logic        resetn;
  logic [5:0]  stallreq;
  logic        load_use;
  logic        excp_req;
  logic [31:0] excp_pc;

  logic [5:0]  stallA, stallB;
  logic        flushA, flushB;
  logic [31:0] newPcA, newPcB;
  logic        tmoA, tmoB;

  int nCmp = 0;
  int nErr = 0;
  bit checkEn = 0;

  // Behavioural model state, index 0 = default instance, 1 = LB3/TMO4.
  // owed = bubbles decode still owes (current cycle included).
  int          owed[2];
  bit          pend[2];
  bit          flushNow[2];
  logic [31:0] mPc[2];
  int          wd[2];
  bit          tmo[2];

  pipe_ctrl_n dutA (
    .clk(clk), .resetn(resetn), .stallreq(stallreq), .load_use(load_use),
    .excp_req(excp_req), .excp_pc(excp_pc), .stall(stallA), .flush(flushA),
    .new_pc(newPcA), .stall_tmo(tmoA)
  );

  pipe_ctrl_n #(.LOAD_BUBBLE(3), .TMO_W(4)) dutB (
    .clk(clk), .resetn(resetn), .stallreq(stallreq), .load_use(load_use),
    .excp_req(excp_req), .excp_pc(excp_pc), .stall(stallB), .flush(flushB),
    .new_pc(newPcB), .stall_tmo(tmoB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int bubOf(int m);
    return (m == 0) ? 1 : 3;
  endfunction

  function automatic int wdMaxOf(int m);
    return (m == 0) ? 255 : 15;
  endfunction

  function automatic logic [5:0] expStall(int m);
    int top;
    logic [6:0] ones;
    if (flushNow[m]) return 6'b0;
    top = -1;
    for (int i = 0; i < 6; i++) if (stallreq[i]) top = i;
    if (resetn && (owed[m] > 0 || (!pend[m] && load_use && !excp_req)) && top < 2)
      top = 2;
    ones = 7'((1 << (top + 1)) - 1);
    return ones[5:0];
  endfunction

  task automatic resetModel(int m);
    owed[m] = 0; pend[m] = 0; flushNow[m] = 0; mPc[m] = 32'd0; wd[m] = 0; tmo[m] = 0;
  endtask

  task automatic advanceModel(int m, logic [5:0] s);
    bit blkId;
    bit blkEx;
    blkId = |stallreq[5:3];
    blkEx = stallreq[5];
    if (s != 6'd0) begin
      if (wd[m] < wdMaxOf(m)) wd[m] = wd[m] + 1;
    end else begin
      wd[m] = 0;
    end
    if (wd[m] == wdMaxOf(m)) tmo[m] = 1;
    if (flushNow[m]) begin
      flushNow[m] = 0;
    end else if (pend[m]) begin
      if (!blkEx) begin
        pend[m] = 0;
        flushNow[m] = 1;
      end
    end else if (excp_req) begin
      mPc[m] = excp_pc;
      owed[m] = 0;
      if (blkEx) pend[m] = 1;
      else flushNow[m] = 1;
    end else if (owed[m] > 0) begin
      if (!blkId) owed[m] = owed[m] - 1;
    end else if (load_use) begin
      owed[m] = blkId ? bubOf(m) : bubOf(m) - 1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compareInst(int m, logic [5:0] st, logic fl, logic [31:0] pc, logic tm);
    logic [5:0] s;
    s = expStall(m);
    checkOutput($sformatf("model stall[%0d]", m), {26'd0, st}, {26'd0, s});
    checkOutput($sformatf("model flush[%0d]", m), {31'd0, fl}, {31'd0, flushNow[m]});
    checkOutput($sformatf("model new_pc[%0d]", m), pc, mPc[m]);
    checkOutput($sformatf("model stall_tmo[%0d]", m), {31'd0, tm}, {31'd0, tmo[m]});
    if (resetn) advanceModel(m, s);
  endtask

  // Compare process: inputs are stable across the falling edge, so the
  // model is checked and then stepped for the upcoming rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (checkEn) begin
        if (!resetn) begin
          resetModel(0);
          resetModel(1);
        end
        compareInst(0, stallA, flushA, newPcA, tmoA);
        compareInst(1, stallB, flushB, newPcB, tmoB);
      end
    end
  end

  task automatic applyStimulus(input logic [5:0] sr, input logic lu, input logic ex, input logic [31:0] pc);
    @(posedge clk);
    #1;
    stallreq = sr;
    load_use = lu;
    excp_req = ex;
    excp_pc  = pc;
  endtask

  task automatic idleCycles(int n);
    for (int i = 0; i < n; i++) applyStimulus(6'd0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    logic [5:0] sr;
    resetn = 1'b0; stallreq = 6'd0; load_use = 1'b0; excp_req = 1'b0; excp_pc = 32'd0;
    resetModel(0);
    resetModel(1);
    checkEn = 1;

    // Reset state, with a load_use that must not reach stall during reset.
    load_use = 1'b1;
    stallreq = 6'b000010;
    @(negedge clk);
    checkOutput("rst stall", {26'd0, stallA}, 32'h03);
    checkOutput("rst flush", {31'd0, flushA}, 32'd0);
    checkOutput("rst new_pc", newPcA, 32'd0);
    checkOutput("rst tmo", {31'd0, tmoB}, 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    idleCycles(2);

    // Single load_use with default bubble.
    applyStimulus(6'd0, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("lu1 stallA", {26'd0, stallA}, 32'h07);
    applyStimulus(6'd0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("lu1 stallA after", {26'd0, stallA}, 32'h00);
    checkOutput("lu3 free stallB", {26'd0, stallB}, 32'h07);
    idleCycles(4);

    // LOAD_BUBBLE=3 with younger stall on stage 4 for two cycles.
    applyStimulus(6'b010000, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("lu3 blk0", {26'd0, stallB}, 32'h1F);
    applyStimulus(6'b010000, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("lu3 blk1", {26'd0, stallB}, 32'h1F);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(6'd0, 1'b0, 1'b0, 32'd0);
      @(negedge clk);
      checkOutput($sformatf("lu3 bubble%0d", i), {26'd0, stallB}, 32'h07);
    end
    applyStimulus(6'd0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("lu3 done", {26'd0, stallB}, 32'h00);
    idleCycles(2);

    // Immediate exception; a second request during FLUSH is dropped.
    applyStimulus(6'd0, 1'b0, 1'b1, 32'hBFC00380);
    @(negedge clk);
    checkOutput("exc flush0", {31'd0, flushA}, 32'd0);
    applyStimulus(6'h3F, 1'b0, 1'b1, 32'h11111111);
    @(negedge clk);
    checkOutput("exc flush1", {31'd0, flushA}, 32'd1);
    checkOutput("exc new_pc", newPcA, 32'hBFC00380);
    checkOutput("exc stall zero", {26'd0, stallA}, 32'h00);
    applyStimulus(6'd0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("exc flush2", {31'd0, flushA}, 32'd0);
    checkOutput("exc pc held", newPcB, 32'hBFC00380);
    idleCycles(2);

    // Exception held pending behind WB stall for four cycles.
    applyStimulus(6'b100000, 1'b0, 1'b1, 32'h80000180);
    @(negedge clk);
    checkOutput("pend flush c0", {31'd0, flushA}, 32'd0);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(6'b100000, 1'b1, 1'b1, 32'hDEADBEEF);
      @(negedge clk);
      checkOutput($sformatf("pend flush c%0d", i), {31'd0, flushA}, 32'd0);
      checkOutput($sformatf("pend stall c%0d", i), {26'd0, stallA}, 32'h3F);
    end
    applyStimulus(6'd0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("pend flush c4", {31'd0, flushA}, 32'd0);
    applyStimulus(6'd0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("pend flush c5", {31'd0, flushB}, 32'd1);
    checkOutput("pend new_pc", newPcA, 32'h80000180);
    idleCycles(2);

    // Reset during PEND abandons the exception.
    applyStimulus(6'b100000, 1'b0, 1'b1, 32'h12345678);
    applyStimulus(6'b100000, 1'b0, 1'b0, 32'd0);
    @(posedge clk);
    #1 resetn = 1'b0;
    @(negedge clk);
    checkOutput("rstpend new_pc", newPcA, 32'd0);
    checkOutput("rstpend stall", {26'd0, stallA}, 32'h3F);
    checkOutput("rstpend tmo", {31'd0, tmoA}, 32'd0);
    applyStimulus(6'd0, 1'b0, 1'b0, 32'd0);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("rstpend noflush%0d", i), {31'd0, flushA | flushB}, 32'd0);
      applyStimulus(6'd0, 1'b0, 1'b0, 32'd0);
    end

    // Watchdog on the 4-bit instance: stage 0 held 20 cycles.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(6'b000001, 1'b0, 1'b0, 32'd0);
      @(negedge clk);
      checkOutput($sformatf("tmo c%0d", i), {31'd0, tmoB}, (i >= 15) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(6'd0, 1'b0, 1'b0, 32'd0);
      @(negedge clk);
      checkOutput($sformatf("tmo sticky%0d", i), {31'd0, tmoB}, 32'd1);
    end
    checkOutput("tmo A clear", {31'd0, tmoA}, 32'd0);
    @(posedge clk);
    #1 resetn = 1'b0;
    @(negedge clk);
    checkOutput("tmo reset", {31'd0, tmoB}, 32'd0);
    applyStimulus(6'd0, 1'b0, 1'b0, 32'd0);
    resetn = 1'b1;

    // Randomized phase, checked by the compare process.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      sr = 6'd0;
      for (int b = 0; b < 6; b++) sr[b] = ($urandom_range(0, 9) == 0);
      if ((cyc % 250) < 22) begin
        sr[0] = 1'b1;
        applyStimulus(sr, $urandom_range(0, 3) == 0, 1'b0, 32'd0);
      end else begin
        applyStimulus(sr, $urandom_range(0, 3) == 0, $urandom_range(0, 12) == 0, $urandom);
      end
      resetn = ($urandom_range(0, 199) != 0);
    end
    applyStimulus(6'd0, 1'b0, 1'b0, 32'd0);
    resetn = 1'b1;
    idleCycles(3);
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_n.md
PIPE_CTRL_N -- requirements
Module: pipe_ctrl_n

Interface
REQ-001 Parameter STAGES, default 6, number of pipeline stages controlled (index 0 = PC/IF, STAGES-1 = WB).
REQ-002 Parameter ID_IDX, default 2, stage index of decode, the target of load-use bubbles.
REQ-003 Parameter EXCP_IDX, default 4, stage index where exceptions are detected.
REQ-004 Parameter LOAD_BUBBLE, default 1, stall cycles inserted per load-use hazard (range 1..15).
REQ-005 Parameter TMO_W, default 8, width of the stall watchdog counter.
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 resetn  input  1  asynchronous, active-low reset.
REQ-008 stallreq  input  STAGES  per-stage stall request, bit i from stage i.
REQ-009 load_use  input  1  decode reports a load-use hazard this cycle.
REQ-010 excp_req  input  1  exception request from stage EXCP_IDX, single-cycle pulse.
REQ-011 excp_pc  input  32  handler target PC accompanying excp_req.
REQ-012 stall  output  STAGES  per-stage hold, bit i = 1 freezes stage i.
REQ-013 flush  output  1  one-cycle pipeline flush pulse.
REQ-014 new_pc  output  32  redirect PC, valid while flush=1.
REQ-015 stall_tmo  output  1  sticky watchdog flag.

Function
REQ-016 The highest-index active stall source is k; stall SHALL equal ones in bits 0..k and zero above (stage k+1 receives a bubble).
REQ-017 Stall sources SHALL be stallreq[i] (combinational, same cycle) and the LOAD state (source index ID_IDX).
REQ-018 FSM states SHALL be IDLE, LOAD, PEND, FLUSH.
REQ-019 IDLE -> LOAD when load_use=1 and no excp_req; counter loads LOAD_BUBBLE-1; stall from index ID_IDX asserted starting the same cycle as load_use.
REQ-020 LOAD holds index-ID_IDX stall; counter decrements only when no stallreq bit above ID_IDX is set; returns to IDLE in the cycle after the counter reaches 0.
REQ-021 excp_req=1 in IDLE or LOAD SHALL capture excp_pc into new_pc and go to FLUSH, unless any stallreq bit with index > EXCP_IDX is set, then go to PEND.
REQ-022 PEND SHALL hold the captured PC, ignore further excp_req and load_use, and go to FLUSH in the cycle after all stallreq bits above EXCP_IDX are clear.
REQ-023 FLUSH lasts exactly one cycle: flush=1, stall=all zero regardless of stallreq, then IDLE; an excp_req during FLUSH SHALL be dropped.
REQ-024 load_use together with excp_req SHALL be resolved in favour of the exception; a pending LOAD count is discarded on entering PEND/FLUSH.
REQ-025 flush SHALL be a registered output; stall SHALL be combinational from state and inputs.
REQ-026 Watchdog: TMO_W-bit counter increments each cycle any stall bit is 1, clears when stall is all zero, saturates at all ones; stall_tmo SHALL set when the counter saturates and stay set until reset.
REQ-027 new_pc SHALL hold its last captured value outside FLUSH.

Reset
REQ-028 resetn=0 SHALL immediately force state IDLE, flush=0, new_pc=0, stall_tmo=0, counters 0, with stall then driven only by stallreq (REQ-016).
REQ-029 Reset asserted mid-LOAD or mid-PEND SHALL abandon the bubble/pending exception; no flush is produced after release.

Verification
REQ-030 Defaults, stallreq=0, load_use pulse 1 cycle -> stall=6'b000111 for exactly 1 cycle, then 0.
REQ-031 LOAD_BUBBLE=3, load_use pulse while stallreq[4]=1 for 2 cycles -> stall=6'b011111 two cycles, then 6'b000111 three cycles.
REQ-032 excp_req with excp_pc=32'hBFC00380, stallreq=0 -> next cycle flush=1, new_pc=32'hBFC00380, stall=0; following cycle flush=0.
REQ-033 excp_req while stallreq[5]=1 for 4 cycles -> PEND, flush=0 during stall, flush=1 one cycle after stallreq[5] clears.
REQ-034 TMO_W=4, stallreq[0] held 20 cycles -> stall_tmo=1 at cycle 15, remains 1 after stallreq drops until resetn=0.
REQ-035 resetn pulsed low during PEND -> flush never asserts, stall_tmo=0, new_pc=0.
